// File: rtl/tmds_pkg.sv
// tmds_pkg: shared mode type, disparity type and fixed symbol constants
// used by the multi-channel TMDS encoder and its per-channel engine.
package tmds_pkg;

  // Per-symbol operating mode carried alongside each input byte
  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_GUARD = 2'b10,
    MODE_RSVD  = 2'b11
  } tmds_mode_e;

  // Running disparity: 5-bit two's complement, wraps rather than saturates
  typedef logic signed [4:0] disp_t;

  // Control-period tokens indexed by {C1,C0}, written as bits 9..0
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Guard-band symbols; even channels use GUARD_EVEN, odd channels GUARD_ODD
  localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
  localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

  // Number of ones in a byte (0..8)
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Map the two control bits onto their control-period token
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// tmds_channel_enc: one TMDS lane. Stage 1 turns the pixel byte into the
// transition-minimised q_m word; stage 2 picks the DC-balancing inversion
// (or a control / guard symbol) and tracks this lane's running disparity.
module tmds_channel_enc
  import tmds_pkg::*;
#(
  parameter int CH_IDX = 0,
  parameter int GB_EN  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_hold,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  tmds_mode_e i_mode,
  input  logic       i_s1_valid,
  output logic [9:0] o_tmds,
  output disp_t      o_disparity
);

  // Stage-1 state
  logic [8:0] r_q_m;
  tmds_mode_e r_mode;
  logic [1:0] r_ctrl;

  // Stage-2 state
  logic [9:0] r_tmds;
  disp_t      r_cnt;

  // Stage-1 combinational encoding
  logic [3:0] w_n1_d;
  logic       w_use_xnor;
  logic [8:0] w_q_m;

  // Stage-2 combinational balancing
  logic              w_qm8;
  logic [7:0]        w_qm_lo;
  logic [3:0]        w_n1_q;
  logic [3:0]        w_n0_q;
  logic signed [5:0] w_cnt_ext;
  logic signed [5:0] w_bal;
  logic signed [5:0] w_cnt_next;
  logic [9:0]        w_sym;

  // Transition minimisation: XNOR chain for bytes heavy in ones, XOR otherwise
  always_comb begin
    w_n1_d     = popcount8(i_data);
    w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !i_data[0]);
    w_q_m      = '0;
    w_q_m[0]   = i_data[0];
    for (int i = 1; i < 8; i++) begin
      w_q_m[i] = w_use_xnor ? ~(w_q_m[i-1] ^ i_data[i]) : (w_q_m[i-1] ^ i_data[i]);
    end
    w_q_m[8] = ~w_use_xnor;
  end

  // Symbol selection and next disparity; all sums done 6 bits wide, then wrapped to 5
  always_comb begin
    w_qm8      = r_q_m[8];
    w_qm_lo    = r_q_m[7:0];
    w_n1_q     = popcount8(w_qm_lo);
    w_n0_q     = 4'd8 - w_n1_q;
    w_cnt_ext  = {r_cnt[4], r_cnt};
    w_bal      = $signed({2'b00, w_n1_q}) - $signed({2'b00, w_n0_q});
    w_sym      = '0;
    w_cnt_next = w_cnt_ext;
    case (r_mode)
      MODE_VIDEO: begin
        if ((r_cnt == 5'sd0) || (w_n1_q == w_n0_q)) begin
          // Neutral case: invert only when XNOR chaining was used
          w_sym      = {~w_qm8, w_qm8, (w_qm8 ? w_qm_lo : ~w_qm_lo)};
          w_cnt_next = w_qm8 ? (w_cnt_ext + w_bal) : (w_cnt_ext - w_bal);
        end else if (((r_cnt > 5'sd0) && (w_n1_q > w_n0_q)) ||
                     ((r_cnt < 5'sd0) && (w_n0_q > w_n1_q))) begin
          // Disparity would grow further: send inverted data
          w_sym      = {1'b1, w_qm8, ~w_qm_lo};
          w_cnt_next = w_cnt_ext - w_bal + (w_qm8 ? 6'sd2 : 6'sd0);
        end else begin
          // Disparity is pulled back toward zero by sending data as-is
          w_sym      = {1'b0, w_qm8, w_qm_lo};
          w_cnt_next = w_cnt_ext + w_bal - (w_qm8 ? 6'sd0 : 6'sd2);
        end
      end
      MODE_GUARD: begin
        if (GB_EN != 0) begin
          // Guard bands are DC-neutral over time, so disparity is left alone
          w_sym      = ((CH_IDX % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
          w_cnt_next = w_cnt_ext;
        end else begin
          w_sym      = ctrl_token(r_ctrl);
          w_cnt_next = '0;
        end
      end
      default: begin
        // Control period (and the reserved mode) restarts DC balance
        w_sym      = ctrl_token(r_ctrl);
        w_cnt_next = '0;
      end
    endcase
  end

  // Stage 1: capture q_m with this symbol's mode and control bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q_m  <= '0;
      r_mode <= MODE_CTRL;
      r_ctrl <= '0;
    end else if (!i_hold) begin
      r_q_m  <= w_q_m;
      r_mode <= i_mode;
      r_ctrl <= i_ctrl;
    end
  end

  // Stage 2: update symbol and disparity only for real symbols, never for bubbles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmds <= '0;
      r_cnt  <= '0;
    end else if (!i_hold && i_s1_valid) begin
      r_tmds <= w_sym;
      r_cnt  <= w_cnt_next[4:0];
    end
  end

  assign o_tmds      = r_tmds;
  assign o_disparity = r_cnt;

endmodule

// File: rtl/tmds_multi_encoder.sv
// tmds_multi_encoder: NUM_CH parallel TMDS lanes sharing one valid/hold
// pipeline, with a sticky flag for symbols that arrive in the reserved mode.
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int GB_EN  = 1
) (
  input  logic                   system_clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [1:0]             mode,
  input  logic [NUM_CH*8-1:0]    data_in,
  input  logic [NUM_CH*2-1:0]    ctrl_in,
  input  logic                   hold,
  output logic                   out_valid,
  output logic [NUM_CH*10-1:0]   tmds_out,
  output logic [NUM_CH*5-1:0]    disparity,
  output logic                   mode_err
);

  logic       r_valid_s1;
  logic       r_out_valid;
  logic       r_mode_err;
  tmds_mode_e w_mode;

  assign w_mode = tmds_mode_e'(mode);

  // Valid travels alongside the data; hold freezes it like every other stage
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      r_valid_s1  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!hold) begin
      r_valid_s1  <= in_valid;
      r_out_valid <= r_valid_s1;
    end
  end

  // Sticky error for any accepted symbol using the reserved mode
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      r_mode_err <= 1'b0;
    end else if (!hold && in_valid && (w_mode == MODE_RSVD)) begin
      r_mode_err <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tmds_channel_enc #(
        .CH_IDX (gi),
        .GB_EN  (GB_EN)
      ) u_enc (
        .i_clk       (system_clk),
        .i_rst       (rst),
        .i_hold      (hold),
        .i_data      (data_in[gi*8 +: 8]),
        .i_ctrl      (ctrl_in[gi*2 +: 2]),
        .i_mode      (w_mode),
        .i_s1_valid  (r_valid_s1),
        .o_tmds      (tmds_out[gi*10 +: 10]),
        .o_disparity (disparity[gi*5 +: 5])
      );
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign mode_err  = r_mode_err;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// tb_tmds_multi_encoder: directed and randomised checks of the 3-lane TMDS
// encoder against a symbol-level reference model; a GB_EN=0 copy runs in
// parallel on the same stimulus.
module tb_tmds_multi_encoder;

  localparam int NCH = 3;

  typedef struct packed {
    logic [9:0] sym;
    int         cnt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic [23:0] data_in;
  logic [5:0]  ctrl_in;
  logic        hold;

  logic        a_ov, b_ov, a_me, b_me;
  logic [29:0] a_tmds, b_tmds;
  logic [14:0] a_disp, b_disp;

  logic        ov_w [2];
  logic        me_w [2];
  logic [29:0] tm_w [2];
  logic [14:0] dp_w [2];

  assign ov_w[0] = a_ov;   assign ov_w[1] = b_ov;
  assign me_w[0] = a_me;   assign me_w[1] = b_me;
  assign tm_w[0] = a_tmds; assign tm_w[1] = b_tmds;
  assign dp_w[0] = a_disp; assign dp_w[1] = b_disp;

  int          n_vec = 0;
  int          n_err = 0;
  bit          dec_en = 1'b0;
  logic [23:0] qd [$];
  string       cur_ph = "init";

  always #5 clk = ~clk;

  tmds_multi_encoder #(.NUM_CH(NCH), .GB_EN(1)) dut_a (
    .system_clk (clk), .rst (rst), .in_valid (in_valid), .mode (mode),
    .data_in (data_in), .ctrl_in (ctrl_in), .hold (hold),
    .out_valid (a_ov), .tmds_out (a_tmds), .disparity (a_disp), .mode_err (a_me)
  );

  tmds_multi_encoder #(.NUM_CH(NCH), .GB_EN(0)) dut_b (
    .system_clk (clk), .rst (rst), .in_valid (in_valid), .mode (mode),
    .data_in (data_in), .ctrl_in (ctrl_in), .hold (hold),
    .out_valid (b_ov), .tmds_out (b_tmds), .disparity (b_disp), .mode_err (b_me)
  );

  // ---------------- reference model ----------------
  function automatic int wrap5(input int x);
    int y;
    y = x & 31;
    if (y >= 16) y = y - 32;
    return y;
  endfunction

  // Whole-symbol encoder: byte/mode/ctrl plus current disparity -> symbol, new disparity
  function automatic res_t enc(input logic [7:0] d, input logic [1:0] md, input logic [1:0] c,
                               input int k, input int gb, input int cnt);
    res_t       r;
    int         n1d, n1, n0, b8;
    logic [8:0] qm;
    logic [7:0] qq;
    r.sym = '0;
    r.cnt = cnt;
    if (md == 2'b01) begin
      n1d = $countones(d);
      qm = '0;
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
        for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
        qm[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
        qm[8] = 1'b1;
      end
      qq = qm[7:0];
      n1 = $countones(qq);
      n0 = 8 - n1;
      b8 = qm[8] ? 1 : 0;
      if (cnt == 0 || n1 == n0) begin
        r.sym = {~qm[8], qm[8], (qm[8] ? qq : ~qq)};
        r.cnt = cnt + ((b8 == 1) ? (n1 - n0) : (n0 - n1));
      end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
        r.sym = {1'b1, qm[8], ~qq};
        r.cnt = cnt + 2 * b8 + (n0 - n1);
      end else begin
        r.sym = {1'b0, qm[8], qq};
        r.cnt = cnt - 2 * (1 - b8) + (n1 - n0);
      end
      r.cnt = wrap5(r.cnt);
    end else if (md == 2'b10 && gb != 0) begin
      r.sym = ((k % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
    end else begin
      case (c)
        2'b00:   r.sym = 10'b1101010100;
        2'b01:   r.sym = 10'b0010101011;
        2'b10:   r.sym = 10'b0101010100;
        default: r.sym = 10'b1010101011;
      endcase
      r.cnt = 0;
    end
    return r;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  logic        m_s1_v, m_ov, m_me;
  logic [23:0] m_s1_d;
  logic [1:0]  m_s1_m;
  logic [5:0]  m_s1_c;
  res_t        m_res [2][NCH];

  // Model of the two-cycle pipeline: raw inputs wait one cycle, then encode as a whole
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1_v <= 1'b0; m_ov <= 1'b0; m_me <= 1'b0;
      m_s1_d <= '0;   m_s1_m <= '0; m_s1_c <= '0;
      for (int g = 0; g < 2; g++)
        for (int k = 0; k < NCH; k++) m_res[g][k] <= '{sym: 10'd0, cnt: 0};
    end else if (!hold) begin
      m_ov <= m_s1_v;
      if (m_s1_v)
        for (int g = 0; g < 2; g++)
          for (int k = 0; k < NCH; k++)
            m_res[g][k] <= enc(m_s1_d[8*k +: 8], m_s1_m, m_s1_c[2*k +: 2], k,
                               (g == 0) ? 1 : 0, m_res[g][k].cnt);
      m_s1_v <= in_valid;
      m_s1_d <= data_in;
      m_s1_m <= mode;
      m_s1_c <= ctrl_in;
      if (in_valid && mode == 2'b11) m_me <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %h expected %h", cur_ph, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0]  e5;
    logic [23:0] eb;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("ov%0d", g), 32'(ov_w[g]), 32'(m_ov));
      chk($sformatf("me%0d", g), 32'(me_w[g]), 32'(m_me));
      for (int k = 0; k < NCH; k++) begin
        e5 = m_res[g][k].cnt[4:0];
        chk($sformatf("disp%0d_%0d", g, k), 32'(dp_w[g][5*k +: 5]), 32'(e5));
        if (m_ov) chk($sformatf("sym%0d_%0d", g, k), 32'(tm_w[g][10*k +: 10]), 32'(m_res[g][k].sym));
      end
    end
    if (dec_en && m_ov && qd.size() > 0) begin
      eb = qd.pop_front();
      for (int k = 0; k < NCH; k++)
        chk($sformatf("decode%0d", k), 32'(dec(a_tmds[10*k +: 10])), 32'(eb[8*k +: 8]));
    end
  endtask

  task automatic chk_zero();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_ov%0d", g), 32'(ov_w[g]), 32'd0);
      chk($sformatf("rst_tmds%0d", g), 32'(tm_w[g]), 32'd0);
      chk($sformatf("rst_disp%0d", g), 32'(dp_w[g]), 32'd0);
      chk($sformatf("rst_me%0d", g), 32'(me_w[g]), 32'd0);
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] md, input logic [23:0] d,
                       input logic [5:0] c, input logic h);
    in_valid = v; mode = md; data_in = d; ctrl_in = c; hold = h;
    @(posedge clk); #1;
    if (dec_en && v && !h) qd.push_back(d);
    $display("[%s] t=%0t v=%b mode=%0d data=%h ctrl=%b hold=%b -> ov=%b tmds=%h disp=%h",
             cur_ph, $time, v, md, d, c, h, a_ov, a_tmds, a_disp);
    check_all();
  endtask

  task automatic reset_dut();
    rst = 1'b1; hold = 1'b1; in_valid = 1'b1; mode = 2'b01;
    data_in = 24'($urandom); ctrl_in = 6'd0;
    @(posedge clk); #1;
    chk_zero();
    @(posedge clk); #1;
    rst = 1'b0; hold = 1'b0; in_valid = 1'b0;
    qd.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; data_in = '0; ctrl_in = '0; hold = 1'b0;

    // Two zero bytes: neutral path then inverted path
    cur_ph = "zero2";
    reset_dut();
    apply(1'b1, 2'b01, 24'h000000, 6'd0, 1'b0);
    apply(1'b1, 2'b01, 24'h000000, 6'd0, 1'b0);
    chk("sym", 32'(a_tmds[9:0]), 32'(10'b0100000000));
    chk("disp", 32'(a_disp[4:0]), 32'h18);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b0);
    chk("sym", 32'(a_tmds[9:0]), 32'(10'b1111111111));
    chk("disp", 32'(a_disp[4:0]), 32'd2);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b0);

    // 0xFF then a control token clears disparity
    cur_ph = "ff_ctrl";
    reset_dut();
    apply(1'b1, 2'b01, 24'hFFFFFF, 6'd0, 1'b0);
    apply(1'b1, 2'b00, 24'h000000, 6'b000000, 1'b0);
    chk("sym", 32'(a_tmds[9:0]), 32'(10'b1000000000));
    chk("disp", 32'(a_disp[4:0]), 32'h18);
    apply(1'b0, 2'b00, 24'h000000, 6'd0, 1'b0);
    chk("sym", 32'(a_tmds[9:0]), 32'(10'b1101010100));
    chk("disp", 32'(a_disp[4:0]), 32'd0);

    // Guard band after a video symbol; GB_EN=0 copy emits control tokens instead
    cur_ph = "guard";
    reset_dut();
    apply(1'b1, 2'b01, 24'h000000, 6'd0, 1'b0);
    apply(1'b1, 2'b10, 24'h5A5A5A, 6'b101010, 1'b0);
    apply(1'b0, 2'b00, 24'h000000, 6'd0, 1'b0);
    chk("g_ch0", 32'(a_tmds[9:0]),   32'(10'b1011001100));
    chk("g_ch1", 32'(a_tmds[19:10]), 32'(10'b0100110011));
    chk("g_ch2", 32'(a_tmds[29:20]), 32'(10'b1011001100));
    chk("g_disp", 32'(a_disp), 32'({5'h18, 5'h18, 5'h18}));
    chk("nogb_ch0", 32'(b_tmds[9:0]),   32'(10'b0101010100));
    chk("nogb_ch1", 32'(b_tmds[19:10]), 32'(10'b0101010100));
    chk("nogb_disp", 32'(b_disp), 32'd0);

    // Hold on the second cycle stretches the valid pattern by one cycle
    cur_ph = "hold";
    reset_dut();
    apply(1'b1, 2'b01, 24'h123456, 6'd0, 1'b0);
    chk("ov_e1", 32'(a_ov), 32'd0);
    apply(1'b1, 2'b01, 24'hDEAD00, 6'd0, 1'b1);
    chk("ov_e2", 32'(a_ov), 32'd0);
    apply(1'b1, 2'b01, 24'h9ABCDE, 6'd0, 1'b0);
    chk("ov_e3", 32'(a_ov), 32'd1);
    apply(1'b1, 2'b01, 24'hF0E1D2, 6'd0, 1'b0);
    chk("ov_e4", 32'(a_ov), 32'd1);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b1);
    chk("ov_e5h", 32'(a_ov), 32'd1);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b0);
    chk("ov_e6", 32'(a_ov), 32'd1);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b0);
    chk("ov_e7", 32'(a_ov), 32'd0);

    // Randomised traffic with bubbles, holds and mode switches
    cur_ph = "random";
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [1:0] md;
      r  = $urandom_range(0, 9);
      md = (r < 2) ? 2'b00 : ((r < 8) ? 2'b01 : 2'b10);
      apply(($urandom_range(0, 9) < 8), md, 24'($urandom), 6'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    // Reserved mode: control token out, sticky error until reset
    cur_ph = "rsvd";
    reset_dut();
    apply(1'b1, 2'b11, 24'h000000, 6'b000001, 1'b0);
    chk("me_now", 32'(a_me), 32'd1);
    apply(1'b0, 2'b01, 24'h000000, 6'd0, 1'b0);
    chk("sym", 32'(a_tmds[9:0]), 32'(10'b0010101011));
    for (int n = 0; n < 3; n++) begin
      apply(1'b1, 2'b01, 24'($urandom), 6'd0, 1'b0);
      chk("me_sticky", 32'(a_me), 32'd1);
    end
    reset_dut();

    // Ramp with a reset pulse in the middle, decoded back to bytes
    cur_ph = "ramp";
    dec_en = 1'b1;
    for (int i = 0; i < 100; i++)
      apply(1'b1, 2'b01, {8'(i + 90), 8'(i + 45), 8'(i)}, 6'd0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_zero();
    #2 rst = 1'b0;
    qd.delete();
    for (int i = 0; i < 256; i++) begin
      apply(1'b1, 2'b01, {8'(i + 90), 8'(i + 45), 8'(i)}, 6'd0, 1'b0);
      if (i == 0) chk("restart_ov0", 32'(a_ov), 32'd0);
      if (i == 1) chk("restart_ov1", 32'(a_ov), 32'd1);
    end
    for (int n = 0; n < 3; n++) apply(1'b0, 2'b01, 24'd0, 6'd0, 1'b0);
    chk("ramp_drained", 32'(qd.size()), 32'd0);
    dec_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_multi_encoder.md
TMDS_MULTI_ENCODER -- requirements
Module: tmds_multi_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent TMDS channels.
REQ-002 SHALL have parameter GB_EN, default 1: 1 enables guard-band mode; 0 makes MODE_GUARD behave as MODE_CTRL.
REQ-003 SHALL have port system_clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: data_in/ctrl_in/mode qualify this cycle.
REQ-006 SHALL have port mode, input, 2: 00 MODE_CTRL, 01 MODE_VIDEO, 10 MODE_GUARD, 11 reserved.
REQ-007 SHALL have port data_in, input, NUM_CH*8: channel k pixel byte at [8k+7:8k].
REQ-008 SHALL have port ctrl_in, input, NUM_CH*2: channel k {C1,C0} at [2k+1:2k].
REQ-009 SHALL have port hold, input, 1: 1 freezes all pipeline registers and disparity counters.
REQ-010 SHALL have port out_valid, output, 1: tmds_out holds a valid symbol.
REQ-011 SHALL have port tmds_out, output, NUM_CH*10: channel k symbol at [10k+9:10k]; bit 0 is transmitted first.
REQ-012 SHALL have port disparity, output, NUM_CH*5: channel k signed running disparity, for debug.
REQ-013 SHALL have port mode_err, output, 1: sticky flag, set when a reserved mode is accepted.

Function
REQ-014 SHALL implement a 2-stage pipeline: stage 1 registers q_m[8:0], mode, and ctrl; stage 2 registers tmds_out; latency is exactly 2 cycles from in_valid to out_valid when hold=0.
REQ-015 SHALL pass in_valid through the pipeline unchanged; out_valid is its 2-cycle-delayed copy; a bubble produces out_valid=0 and leaves disparity unchanged.
REQ-016 SHALL, while hold=1, keep every register including out_valid and disparity constant; inputs are ignored that cycle.
REQ-017 SHALL compute stage 1 per DVI 1.0: N1=popcount(D); if N1>4 or (N1==4 and D[0]==0), use XNOR chaining with q_m[8]=0; otherwise use XOR chaining with q_m[8]=1; q_m[0]=D[0].
REQ-018 SHALL compute stage 2 in MODE_VIDEO for cnt==0 or N1(q_m[7:0])==N0: q_out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8] ? (N1-N0) : (N0-N1).
REQ-019 SHALL, else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): q_out={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
REQ-020 SHALL, otherwise: q_out={0, q_m[8], q_m[7:0]}; cnt += -2*(~q_m[8]) + (N1-N0).
REQ-021 SHALL keep cnt as a 5-bit two's-complement value per channel, using 6-bit intermediate arithmetic, and SHALL NOT saturate.
REQ-022 SHALL output in MODE_CTRL (and for reserved mode 11) these tokens: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (listed as bits 9..0); cnt is cleared to 0.
REQ-023 SHALL output in MODE_GUARD with GB_EN=1: even k -> 1011001100, odd k -> 0100110011; cnt is unchanged.
REQ-024 SHALL apply mode per symbol; a mode change between consecutive valid symbols takes effect on that symbol with no extra latency.
REQ-025 SHALL set mode_err when a valid symbol with mode=11 enters stage 1; it clears only on reset.

Reset
REQ-026 SHALL, while rst=1, force out_valid=0, tmds_out=0, all disparity counters=0, mode_err=0, and stage-1 registers=0, regardless of hold.
REQ-027 SHALL discard all in-flight symbols when reset is asserted mid-stream; the first valid output after release appears 2 cycles after the first accepted in_valid.

Structure
REQ-028 SHALL put the following in shared package tmds_pkg: mode enum, the four control-token constants, the two guard-band constants, and the 5-bit signed disparity typedef.
REQ-029 SHALL instantiate sub-module tmds_channel_enc (one channel, both stages, its own cnt) NUM_CH times via generate.

Verification
REQ-030 SHALL cover: reset, then VIDEO 0x00 on ch0 twice -> tmds_out ch0 0100000000 then 1111111111; disparity -8 then +2.
REQ-031 SHALL cover: reset, then VIDEO 0xFF -> 1000000000, disparity -8; then CTRL ctrl=00 -> 1101010100, disparity 0.
REQ-032 SHALL cover: GUARD with NUM_CH=3 -> ch0/ch2 1011001100, ch1 0100110011; disparity unchanged; GB_EN=0 -> control tokens instead.
REQ-033 SHALL cover: 3 valid symbols with hold=1 on cycle 2 -> outputs and disparity frozen one cycle; out_valid pattern stretched by exactly 1 cycle.
REQ-034 SHALL cover: mode=11 with ctrl=01 -> output 0010101011, mode_err=1 until rst.
REQ-035 SHALL cover: 256-byte ramp 0..255 decoded by a bench model and compared to input bytes, plus rst pulse mid-ramp -> outputs 0 and out_valid=0 immediately, then correct decode after restart.
